hazard_stall_controller: RTL and testbench

Generates the stall and flush controls consumed by the fetch stage and the decode→execute pipeline register. It detects load-use hazards between decode and execute, issues the two-cycle flush after a control-flow redirect resolved in execute, and freezes the front end while data memory is busy. It sits beside the decode stage, and its outputs drive the `stall` input of the decode pipe register and the fetch PC hold.

---
 rtl/hazard_stall_controller.sv | 199 +++++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
//
// Produces the stall and flush controls for the fetch stage and the
// decode->execute pipe register. It detects load-use hazards between decode
// and execute, issues a two-cycle flush after a redirect that is resolved in
// execute, and freezes the front end while data memory is busy.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   : stall_cycles / flush_cycles saturating counters are built and
//               perf_clear is honored.
//   undefined : counter outputs are tied to 0 and perf_clear is ignored.
//
// Ports:
//   clock                  single clock
//   reset                  asynchronous reset, active-low
//   rs1_decode/rs2_decode  source register fields of the decode instruction
//   uses_rs1/rs2_decode    decode instruction actually reads rs1/rs2
//   rd_execute             destination register of the execute instruction
//   memRead_execute        execute instruction is a load
//   next_PC_select_execute non-zero: redirect resolved in execute
//   mem_busy               data memory not ready, pipeline must freeze
//   perf_clear             synchronous clear of the performance counters
//   stall_fetch            hold PC and fetch->decode register
//   stall_decode           bubble into decode->execute
//   flush_decode           squash the instruction in decode
//   ctrl_state             state register, for debug
//   stall_cycles           cycles with stall_decode=1 (saturating)
//   flush_cycles           cycles with flush_decode=1 (saturating)
//
// State table:
//   state    | meaning
//   RUN      | normal flow; load-use stalls are handled in place
//   REDIRECT | second flush cycle after a redirect
//   MEM_WAIT | front end frozen until mem_busy drops, then resume state
//   2'd3     | unused, recovers to RUN on the next edge
// ---------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [4:0]               rs1_decode,
  input  logic [4:0]               rs2_decode,
  input  logic                     uses_rs1_decode,
  input  logic                     uses_rs2_decode,
  input  logic [4:0]               rd_execute,
  input  logic                     memRead_execute,
  input  logic [1:0]               next_PC_select_execute,
  input  logic                     mem_busy,
  input  logic                     perf_clear,
  output logic                     stall_fetch,
  output logic                     stall_decode,
  output logic                     flush_decode,
  output logic [1:0]               ctrl_state,
  output logic [COUNTER_WIDTH-1:0] stall_cycles,
  output logic [COUNTER_WIDTH-1:0] flush_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;
  state_t resume_q, resume_d;
  state_t eval_state;

  logic load_use;
  logic redirect;
  logic stall_raw;
  logic flush_raw;

  assign load_use = memRead_execute && (rd_execute != 5'd0) &&
                    ((uses_rs1_decode && (rs1_decode == rd_execute)) ||
                     (uses_rs2_decode && (rs2_decode == rd_execute)));

  assign redirect = (next_PC_select_execute != 2'b00);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      resume_q <= RUN;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
    end
  end

  // Once memory releases, the cycle behaves exactly as the saved state would,
  // so the rules are evaluated against the resume state rather than MEM_WAIT.
  always_comb begin
    eval_state = state_q;
    if ((state_q == MEM_WAIT) && !mem_busy) begin
      eval_state = resume_q;
    end
  end

  always_comb begin
    state_d   = RUN;
    resume_d  = resume_q;
    stall_raw = 1'b0;
    flush_raw = 1'b0;

    case (eval_state)
      RUN: begin
        if (mem_busy) begin
          stall_raw = 1'b1;
          resume_d  = RUN;
          state_d   = MEM_WAIT;
        end else if (redirect) begin
          flush_raw = 1'b1;
          state_d   = REDIRECT;
        end else if (load_use) begin
          stall_raw = 1'b1;
          state_d   = RUN;
        end else begin
          state_d   = RUN;
        end
      end

      REDIRECT: begin
        if (mem_busy) begin
          stall_raw = 1'b1;
          resume_d  = REDIRECT;
          state_d   = MEM_WAIT;
        end else begin
          // load_use is ignored: the decode instruction is being squashed.
          flush_raw = 1'b1;
          state_d   = redirect ? REDIRECT : RUN;
        end
      end

      MEM_WAIT: begin
        // Only reachable with mem_busy=1, or with a corrupted resume value,
        // in which case falling back to RUN is the safe recovery.
        if (mem_busy) begin
          stall_raw = 1'b1;
          state_d   = MEM_WAIT;
        end else begin
          state_d   = RUN;
        end
      end

      default: begin
        state_d  = RUN;
        resume_d = RUN;
      end
    endcase
  end

  // Outputs are forced low for the whole time reset is held, independent of
  // whatever the pipeline presents on the inputs.
  always_comb begin
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    flush_decode = 1'b0;
    if (reset) begin
      stall_fetch  = stall_raw;
      stall_decode = stall_raw;
      flush_decode = flush_raw;
    end
  end

  assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [COUNTER_WIDTH-1:0] stall_cnt_q;
  logic [COUNTER_WIDTH-1:0] flush_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (perf_clear) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_decode && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_decode && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`else
  logic unused_perf_clear;

  assign unused_perf_clear = perf_clear;
  assign stall_cycles      = '0;
  assign flush_cycles      = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic [4:0]    rs1_decode;
  logic [4:0]    rs2_decode;
  logic          uses_rs1_decode;
  logic          uses_rs2_decode;
  logic [4:0]    rd_execute;
  logic          memRead_execute;
  logic [1:0]    next_PC_select_execute;
  logic          mem_busy;
  logic          perf_clear;
  logic          stall_fetch;
  logic          stall_decode;
  logic          flush_decode;
  logic [1:0]    ctrl_state;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_cycles;

  hazard_stall_controller #(.COUNTER_WIDTH(CW)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .rs1_decode             (rs1_decode),
    .rs2_decode             (rs2_decode),
    .uses_rs1_decode        (uses_rs1_decode),
    .uses_rs2_decode        (uses_rs2_decode),
    .rd_execute             (rd_execute),
    .memRead_execute        (memRead_execute),
    .next_PC_select_execute (next_PC_select_execute),
    .mem_busy               (mem_busy),
    .perf_clear             (perf_clear),
    .stall_fetch            (stall_fetch),
    .stall_decode           (stall_decode),
    .flush_decode           (flush_decode),
    .ctrl_state             (ctrl_state),
    .stall_cycles           (stall_cycles),
    .flush_cycles           (flush_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string         nm;
    logic          stall;
    logic          flush;
    logic [1:0]    st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] sc_m = '0;
  logic [CW-1:0] fc_m = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: every cycle the controller presents a response; compare it with
  // the oldest queued expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.nm, ".stall_fetch"},  {31'd0, stall_fetch},  {31'd0, e.stall});
      chk({e.nm, ".stall_decode"}, {31'd0, stall_decode}, {31'd0, e.stall});
      chk({e.nm, ".flush_decode"}, {31'd0, flush_decode}, {31'd0, e.flush});
      chk({e.nm, ".ctrl_state"},   {30'd0, ctrl_state},   {30'd0, e.st});
      chk({e.nm, ".stall_cycles"}, 32'(stall_cycles),     32'(e.sc));
      chk({e.nm, ".flush_cycles"}, 32'(flush_cycles),     32'(e.fc));
    end
  end

  task automatic drive(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic [4:0] rd, input logic mr,
                       input logic [1:0] npc, input logic mb, input logic pc);
    rs1_decode             = r1;
    uses_rs1_decode        = u1;
    rs2_decode             = r2;
    uses_rs2_decode        = u2;
    rd_execute             = rd;
    memRead_execute        = mr;
    next_PC_select_execute = npc;
    mem_busy               = mb;
    perf_clear             = pc;
  endtask

  // One cycle of stimulus. Counter expectations show the value before this
  // cycle's edge; the model then advances with the expected outputs.
  task automatic step(input string nm,
                      input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                      input logic u2, input logic [4:0] rd, input logic mr,
                      input logic [1:0] npc, input logic mb, input logic pc,
                      input logic e_stall, input logic e_flush, input logic [1:0] e_st);
    exp_t e;
    @(posedge clock);
    #1;
    drive(r1, u1, r2, u2, rd, mr, npc, mb, pc);
    e.nm    = nm;
    e.stall = e_stall;
    e.flush = e_flush;
    e.st    = e_st;
    e.sc    = CNT_EN ? sc_m : '0;
    e.fc    = CNT_EN ? fc_m : '0;
    exp_q.push_back(e);
    if (pc) begin
      sc_m = '0;
      fc_m = '0;
    end else begin
      if (e_stall && (sc_m != CNT_MAX)) sc_m = sc_m + 1'b1;
      if (e_flush && (fc_m != CNT_MAX)) fc_m = fc_m + 1'b1;
    end
  endtask

  task automatic idle(input string nm, input logic [1:0] e_st);
    step(nm, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, e_st);
  endtask

  task automatic chk_reset_quiet(input string nm);
    chk({nm, ".stall_fetch"},  {31'd0, stall_fetch},  32'd0);
    chk({nm, ".stall_decode"}, {31'd0, stall_decode}, 32'd0);
    chk({nm, ".flush_decode"}, {31'd0, flush_decode}, 32'd0);
    chk({nm, ".ctrl_state"},   {30'd0, ctrl_state},   32'd0);
    chk({nm, ".stall_cycles"}, 32'(stall_cycles),     32'd0);
    chk({nm, ".flush_cycles"}, 32'(flush_cycles),     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    // Hazards presented while in reset must not reach the outputs.
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0);
    #1;
    chk_reset_quiet("in_reset");
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    //    name          r1  u1   r2  u2   rd  mr   npc  mb   pc   stall flush state
    idle("idle", 2'd0);
    step("lu_rs1",     5'd5, 1, 5'd0, 0, 5'd5, 1, 2'b00, 0, 0, 1, 0, 2'd0);
    idle("lu_clear", 2'd0);
    step("lu_rd0",     5'd0, 1, 5'd0, 0, 5'd0, 1, 2'b00, 0, 0, 0, 0, 2'd0);
    step("lu_rs2",     5'd3, 1, 5'd7, 1, 5'd7, 1, 2'b00, 0, 0, 1, 0, 2'd0);
    step("lu_nouse2",  5'd3, 1, 5'd7, 0, 5'd7, 1, 2'b00, 0, 0, 0, 0, 2'd0);
    step("lu_noload",  5'd7, 1, 5'd0, 0, 5'd7, 0, 2'b00, 0, 0, 0, 0, 2'd0);
    step("redir_n",    5'd5, 1, 5'd0, 0, 5'd5, 1, 2'b01, 0, 0, 0, 1, 2'd0);
    step("redir_n1",   5'd5, 1, 5'd0, 0, 5'd5, 1, 2'b00, 0, 0, 0, 1, 2'd1);
    idle("redir_n2", 2'd0);
    step("rmw_redir",  5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b10, 0, 0, 0, 1, 2'd0);
    step("rmw_busy0",  5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 1, 0, 1, 0, 2'd1);
    step("rmw_busy1",  5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 1, 0, 1, 0, 2'd2);
    step("rmw_busy2",  5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 1, 0, 1, 0, 2'd2);
    step("rmw_flush",  5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0, 1, 2'd2);
    idle("rmw_done", 2'd0);
    step("all3",       5'd9, 1, 5'd0, 0, 5'd9, 1, 2'b01, 1, 0, 1, 0, 2'd0);
    step("all3_wait",  5'd9, 1, 5'd0, 0, 5'd9, 1, 2'b01, 1, 0, 1, 0, 2'd2);
    step("all3_f0",    5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b01, 0, 0, 0, 1, 2'd2);
    step("all3_f1",    5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0, 1, 2'd1);
    idle("all3_done", 2'd0);
    step("rep_r0",     5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b11, 0, 0, 0, 1, 2'd0);
    step("rep_r1",     5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b01, 0, 0, 0, 1, 2'd1);
    step("rep_r2",     5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0, 1, 2'd1);
    idle("rep_done", 2'd0);
    step("run_busy",   5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 1, 0, 1, 0, 2'd0);
    step("run_rel_lu", 5'd4, 0, 5'd4, 1, 5'd4, 1, 2'b00, 0, 0, 1, 0, 2'd2);
    idle("run_done", 2'd0);
    step("rst_redir",  5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b01, 0, 0, 0, 1, 2'd0);

    // Now in REDIRECT with flush active; assert reset between edges.
    @(posedge clock);
    #1;
    drive(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'b01, 1'b0, 1'b0);
    #1;
    chk("pre_rst.flush_decode", {31'd0, flush_decode}, 32'd1);
    #1;
    reset = 1'b0;
    sc_m  = '0;
    fc_m  = '0;
    #1;
    chk_reset_quiet("mid_redirect_rst");
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    #1;
    reset = 1'b1;

    idle("post_rst", 2'd0);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat_%0d", i), 5'd8, 1, 5'd0, 0, 5'd8, 1, 2'b00, 0, 0, 1, 0, 2'd0);
    end
    step("fl_a",       5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b01, 0, 0, 0, 1, 2'd0);
    step("fl_b",       5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 0, 0, 1, 2'd1);
    step("clr",        5'd0, 0, 5'd0, 0, 5'd0, 0, 2'b00, 0, 1, 0, 0, 2'd0);
    idle("clr_done", 2'd0);
    step("prec_a",     5'd8, 1, 5'd0, 0, 5'd8, 1, 2'b00, 0, 0, 1, 0, 2'd0);
    step("prec_clr",   5'd8, 1, 5'd0, 0, 5'd8, 1, 2'b00, 0, 1, 1, 0, 2'd0);
    idle("prec_done", 2'd0);
    idle("final", 2'd0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clock);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
